// File: rtl/tmr_pkg.sv
// Shared types and helpers for the triple-redundant weight loader.
// Optional scrubber is enabled by defining TMR_WEIGHT_LOADER_SCRUB_EN.
package tmr_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  // Number of DIN_W beats needed to cover a given bit count
  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/tmr_weight_loader_if.sv
// Valid/ready stream carrying weight beats into the loader.
interface tmr_weight_loader_if #(
  parameter int unsigned DIN_W = 16
);
  logic             s_valid;
  logic             s_ready;
  logic [DIN_W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/tmr_vote.sv
// Bitwise 2-of-3 majority with a per-bit "copies disagree" flag.
module tmr_vote #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_vote_c,
  output logic [W-1:0] o_disagree_c
);
  assign o_vote_c     = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
  assign o_disagree_c = (i_a ^ i_b) | (i_a ^ i_c);
endmodule

// File: rtl/tmr_weight_loader.sv
// Streams a weight image into three redundant copies and presents the
// bitwise majority. Define TMR_WEIGHT_LOADER_SCRUB_EN to add a background
// scrubber that repairs one DIN_W segment per idle cycle.
module tmr_weight_loader
  import tmr_pkg::*;
#(
  parameter int unsigned WEIGHTS_B = 61616,
  parameter int unsigned DIN_W     = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_start,
  tmr_weight_loader_if.slave     s_if,
  output logic [WEIGHTS_B-1:0]   weights,
  output logic                   load_done,
  output logic                   busy,
  output logic                   err_pulse,
  output logic [CNT_W-1:0]       err_count
);

  localparam int unsigned NB     = ceil_div(WEIGHTS_B, DIN_W);
  localparam int unsigned TOT_W  = NB * DIN_W;
  localparam int unsigned BCNT_W = (NB > 1) ? $clog2(NB) : 1;

  state_t              r_state;
  state_t              w_next_state;
  logic [BCNT_W-1:0]   r_beat_cnt;
  logic                r_load_done;
  logic [TOT_W-1:0]    r_copy_a;
  logic [TOT_W-1:0]    r_copy_b;
  logic [TOT_W-1:0]    r_copy_c;
  logic                w_start;
  logic                w_hs;
  logic                w_last;
  logic                w_ready;
  logic [TOT_W-1:0]    w_vote_full;
  logic [TOT_W-1:0]    w_dis_full;
  logic                w_unused;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next state, handshake and last-beat decode
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_hs         = 1'b0;
    w_last       = 1'b0;
    w_ready      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load_start) begin
          w_start      = 1'b1;
          w_next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_ready = 1'b1;
        w_hs    = s_if.s_valid;
        if (w_hs && (r_beat_cnt == BCNT_W'(NB - 1))) begin
          w_last       = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Beat counter and completion flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt  <= '0;
      r_load_done <= 1'b0;
    end else if (w_start) begin
      r_beat_cnt  <= '0;
      r_load_done <= 1'b0;
    end else if (w_hs) begin
      r_beat_cnt <= w_last ? '0 : r_beat_cnt + BCNT_W'(1);
      if (w_last) r_load_done <= 1'b1;
    end
  end

  tmr_vote #(.W(TOT_W)) u_vote_full (
    .i_a          (r_copy_a),
    .i_b          (r_copy_b),
    .i_c          (r_copy_c),
    .o_vote_c     (w_vote_full),
    .o_disagree_c (w_dis_full)
  );

`ifdef TMR_WEIGHT_LOADER_SCRUB_EN
  localparam int unsigned IDX_W = (TOT_W > 1) ? $clog2(TOT_W) : 1;

  logic [BCNT_W-1:0] r_scrub_ptr;
  logic              r_err_pulse;
  logic [CNT_W-1:0]  r_err_count;
  logic [IDX_W-1:0]  w_seg_lo;
  logic [DIN_W-1:0]  w_seg_a;
  logic [DIN_W-1:0]  w_seg_b;
  logic [DIN_W-1:0]  w_seg_c;
  logic [DIN_W-1:0]  w_seg_vote;
  logic [DIN_W-1:0]  w_seg_dis;
  logic              w_scrub_act;
  logic              w_scrub_fix;

  assign w_seg_lo = IDX_W'(r_scrub_ptr) * IDX_W'(DIN_W);
  assign w_seg_a  = r_copy_a[w_seg_lo +: DIN_W];
  assign w_seg_b  = r_copy_b[w_seg_lo +: DIN_W];
  assign w_seg_c  = r_copy_c[w_seg_lo +: DIN_W];

  tmr_vote #(.W(DIN_W)) u_vote_seg (
    .i_a          (w_seg_a),
    .i_b          (w_seg_b),
    .i_c          (w_seg_c),
    .o_vote_c     (w_seg_vote),
    .o_disagree_c (w_seg_dis)
  );

  // A starting load pre-empts the scrubber in the same cycle
  assign w_scrub_act = (r_state == ST_IDLE) && r_load_done && !load_start;
  assign w_scrub_fix = w_scrub_act && (|w_seg_dis);

  // Scrub pointer walk and saturating error counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scrub_ptr <= '0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= w_scrub_fix;
      if (w_start)
        r_scrub_ptr <= '0;
      else if (w_scrub_act)
        r_scrub_ptr <= (r_scrub_ptr == BCNT_W'(NB - 1)) ? '0 : r_scrub_ptr + BCNT_W'(1);
      if (w_scrub_fix && (r_err_count != '1))
        r_err_count <= r_err_count + CNT_W'(1);
    end
  end

  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
`else
  assign err_pulse = 1'b0;
  assign err_count = '0;
`endif

  // Copy storage: stream shift-in, plus segment repair when scrubbing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_copy_a <= '0;
      r_copy_b <= '0;
      r_copy_c <= '0;
    end else if (w_hs) begin
      r_copy_a <= {s_if.s_data, r_copy_a[TOT_W-1:DIN_W]};
      r_copy_b <= {s_if.s_data, r_copy_b[TOT_W-1:DIN_W]};
      r_copy_c <= {s_if.s_data, r_copy_c[TOT_W-1:DIN_W]};
    end
`ifdef TMR_WEIGHT_LOADER_SCRUB_EN
    else if (w_scrub_fix) begin
      r_copy_a[w_seg_lo +: DIN_W] <= w_seg_vote;
      r_copy_b[w_seg_lo +: DIN_W] <= w_seg_vote;
      r_copy_c[w_seg_lo +: DIN_W] <= w_seg_vote;
    end
`endif
  end

  // Padding bits above WEIGHTS_B and the full-width disagree vector are not observed
  assign w_unused = ^{w_dis_full, w_vote_full};

  assign weights     = w_vote_full[WEIGHTS_B-1:0];
  assign load_done   = r_load_done;
  assign busy        = (r_state == ST_LOAD);
  assign s_if.s_ready = w_ready;

endmodule

// File: tb/tb_tmr_weight_loader.sv
// Directed bench for tmr_weight_loader (WEIGHTS_B=40, DIN_W=16, CNT_W=2).
// Scrubber checks are built when TMR_WEIGHT_LOADER_SCRUB_EN is defined.
module tb_tmr_weight_loader;

  localparam int unsigned WB = 40;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 2;
  localparam int unsigned NB = 3;

  logic          clk;
  logic          rst;
  logic          load_start;
  logic [WB-1:0] weights;
  logic          load_done;
  logic          busy;
  logic          err_pulse;
  logic [CW-1:0] err_count;

  int n_pass;
  int n_total;

  typedef struct {
    logic [15:0] b0;
    logic [15:0] b1;
    logic [15:0] b2;
    bit          gaps;
    logic [39:0] exp_w;
  } vec_t;

  vec_t vecs[5];

  tmr_weight_loader_if #(.DIN_W(DW)) s_if ();

  tmr_weight_loader #(
    .WEIGHTS_B (WB),
    .DIN_W     (DW),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .s_if       (s_if),
    .weights    (weights),
    .load_done  (load_done),
    .busy       (busy),
    .err_pulse  (err_pulse),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  // Pulse load_start for one cycle and confirm the LOAD entry
  task automatic start_load();
    @(posedge clk); #1 load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
    chk("busy_on_start", 64'(busy), 64'd1);
    chk("ready_on_start", 64'(s_if.s_ready), 64'd1);
    chk("done_cleared", 64'(load_done), 64'd0);
  endtask

  // Send three beats, optionally with a gap (and a stray load_start) before each
  task automatic send_beats(input logic [15:0] b0, input logic [15:0] b1,
                            input logic [15:0] b2, input bit gaps,
                            input logic [39:0] exp_w);
    logic [15:0] beats [3];
    beats[0] = b0; beats[1] = b1; beats[2] = b2;
    for (int i = 0; i < 3; i++) begin
      if (gaps) begin
        s_if.s_valid = 1'b0;
        load_start   = (i == 0);
        @(posedge clk); #1 load_start = 1'b0;
        chk("busy_in_gap", 64'(busy), 64'd1);
      end
      s_if.s_valid = 1'b1;
      s_if.s_data  = beats[i];
      @(posedge clk); #1 s_if.s_valid = 1'b0;
    end
    chk("weights", 64'(weights), 64'(exp_w));
    chk("done_after_last", 64'(load_done), 64'd1);
    chk("busy_after_last", 64'(busy), 64'd0);
    chk("ready_after_last", 64'(s_if.s_ready), 64'd0);
  endtask

`ifdef TMR_WEIGHT_LOADER_SCRUB_EN
  task automatic wait_pulse(input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < int'(NB) + 1 && !seen; i++) begin
      @(posedge clk); #1;
      if (err_pulse) seen = 1'b1;
    end
    chk(nm, 64'(seen), 64'd1);
  endtask
`endif

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    load_start = 1'b0;
    s_if.s_valid = 1'b0;
    s_if.s_data = '0;

    vecs[0] = '{16'h1111, 16'h2222, 16'h3333, 1'b0, 40'h33_2222_1111};
    vecs[1] = '{16'h1111, 16'h2222, 16'h3333, 1'b1, 40'h33_2222_1111};
    vecs[2] = '{16'hFFFF, 16'h0000, 16'hABCD, 1'b0, 40'hCD_0000_FFFF};
    vecs[3] = '{16'h1234, 16'h5678, 16'h9AFF, 1'b0, 40'hFF_5678_1234};
    vecs[4] = '{16'hDEAD, 16'hBEEF, 16'hCAFE, 1'b1, 40'hFE_BEEF_DEAD};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_weights", 64'(weights), 64'd0);
    chk("rst_done", 64'(load_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(s_if.s_ready), 64'd0);
    chk("rst_err_pulse", 64'(err_pulse), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      start_load();
      send_beats(vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].gaps, vecs[v].exp_w);
      repeat (2) @(posedge clk);
      #1 chk("hold_weights", 64'(weights), 64'(vecs[v].exp_w));
      chk("idle_err_pulse", 64'(err_pulse), 64'd0);
    end

    // Reset after two of three beats discards everything
    start_load();
    s_if.s_valid = 1'b1; s_if.s_data = 16'hAAAA;
    @(posedge clk); #1 s_if.s_data = 16'hBBBB;
    @(posedge clk); #1 s_if.s_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_weights", 64'(weights), 64'd0);
    chk("midrst_done", 64'(load_done), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    s_if.s_valid = 1'b1; s_if.s_data = 16'h3333;
    @(posedge clk); #1 s_if.s_valid = 1'b0;
    chk("idle_beat_ignored", 64'(weights), 64'd0);
    chk("idle_ready_low", 64'(s_if.s_ready), 64'd0);
    start_load();
    send_beats(16'h1111, 16'h2222, 16'h3333, 1'b0, 40'h33_2222_1111);

`ifdef TMR_WEIGHT_LOADER_SCRUB_EN
    // Single-bit fault in copy B is masked and repaired
    @(posedge clk); #1 dut.r_copy_b = 48'h3333_2222_1131;
    chk("fault_masked", 64'(weights), 64'h33_2222_1111);
    wait_pulse("scrub_pulse1");
    chk("err_count1", 64'(err_count), 64'd1);
    @(posedge clk); #1;
    chk("b_repaired", 64'(dut.r_copy_b), 64'h3333_2222_1111);
    chk("pulse_one_cycle", 64'(err_pulse), 64'd0);

    // Three more faults drive the 2-bit counter into saturation
    dut.r_copy_b = 48'h3333_2226_1111;
    wait_pulse("scrub_pulse2");
    chk("err_count2", 64'(err_count), 64'd2);
    #1 dut.r_copy_c = 48'h3B33_2222_1111;
    wait_pulse("scrub_pulse3");
    chk("err_count3", 64'(err_count), 64'd3);
    #1 dut.r_copy_a = 48'h3333_2222_9111;
    wait_pulse("scrub_pulse4");
    chk("err_count_sat", 64'(err_count), 64'd3);
    repeat (4) @(posedge clk);
    #1 chk("err_count_hold", 64'(err_count), 64'd3);
    chk("a_repaired", 64'(dut.r_copy_a), 64'h3333_2222_1111);

    // load_start wins over a pending correction in every segment
    dut.r_copy_b = 48'h3332_2223_1110;
    load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
    chk("coinc_busy", 64'(busy), 64'd1);
    chk("coinc_ptr", 64'(dut.r_scrub_ptr), 64'd0);
    chk("coinc_no_write", 64'(dut.r_copy_b), 64'h3332_2223_1110);
    chk("coinc_no_pulse", 64'(err_pulse), 64'd0);
    send_beats(16'h4444, 16'h5555, 16'h6666, 1'b0, 40'h66_5555_4444);
    chk("coinc_b_reloaded", 64'(dut.r_copy_b), 64'h6666_5555_4444);
    chk("coinc_count_kept", 64'(err_count), 64'd3);
`else
    // Single-bit fault in copy B is masked; no scrub activity exists
    @(posedge clk); #1;
    force dut.r_copy_b = 48'h3333_2222_1131;
    #1 chk("fault_masked", 64'(weights), 64'h33_2222_1111);
    for (int i = 0; i < int'(NB) + 1; i++) begin
      @(posedge clk); #1;
      chk("no_err_pulse", 64'(err_pulse), 64'd0);
      chk("fault_still_masked", 64'(weights), 64'h33_2222_1111);
    end
    chk("no_err_count", 64'(err_count), 64'd0);
    release dut.r_copy_b;
    #1 rst = 1'b1;
    #1 chk("final_rst_weights", 64'(weights), 64'd0);
    rst = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1);
  end

endmodule
